demux_1to3_buf: RTL and testbench
=================================

# demux_1to3_buf

Registered 1-to-3 demultiplexer: the distributing counterpart of the 3-to-1 select mux. It takes one `size`-bit data stream tagged with a 2-bit select and steers each beat to one of three output channels. Each channel has a one-entry buffer with a valid/ready handshake, so a stalled consumer blocks only beats addressed to it. It sits where one producer (e.g. write-back or a result bus) must feed three independent consumers. Select encoding matches the mux: 00→ch0, 01→ch1, 10→ch2, 11 = no target (beat dropped and counted).

## Interface
- `size`, default 32, data width of input and each output channel.
- `clk_i`  in  1  the single clock; all state updates on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `data_i`  in  size  input data beat.
- `select_i`  in  2  target channel of the current beat.
- `valid_i`  in  1  input beat present.
- `ready_o`  out  1  input beat accepted this cycle when `valid_i && ready_o`.
- `data0_o` / `data1_o` / `data2_o`  out  size  channel 0/1/2 buffered data.
- `valid_o`  out  3  bit k = channel k holds a beat.
- `ready_i`  in  3  bit k = consumer k takes the beat this cycle.
- `drop_o`  out  1  one-cycle pulse, a select-11 beat was accepted on the previous cycle.
- `drop_cnt_o`  out  8  saturating count of dropped beats.

## Operation
- Per channel k: registers `buf_k[size]` and `full_k`. `valid_o[k] = full_k`, `datak_o = buf_k`.
- `ready_o`:
  - 0 while `rst_i` = 1.
  - For select 00/01/10: `!full_k || ready_i[k]` for the addressed k, which allows drain and refill in the same cycle.
  - For select 11: 1.
- Accept to channel k: `buf_k <= data_i`, `full_k <= 1`.
- Drain: `full_k && ready_i[k]` with no accept to k, so `full_k <= 0`. `buf_k` keeps its last value; do not clear it.
- Simultaneous drain and accept on k: the consumer takes the old beat, `buf_k` gets the new one, and `full_k` stays 1.
- `ready_i[k]` while `full_k` = 0 has no effect.
- Channels are independent. A full, stalled channel does not block beats to other channels. Order within a channel is preserved; there is no cross-channel ordering.
- Select 11 accepted: no buffer changes, `drop_o <= 1` for one cycle, `drop_cnt_o <= drop_cnt_o + 1`, saturating at 255 (no wrap).
- Output values while `valid_o[k]` = 0 are don't-care for consumers, but the bench checks hold behaviour.

## Timing
- Reset (synchronous, takes effect on the clock edge with `rst_i` = 1):
  - `full_k` = 0, `buf_k` = 0.
  - `valid_o` = 3'b000, `data*_o` = 0, `drop_o` = 0, `drop_cnt_o` = 0.
  - `ready_o` = 0 while `rst_i` is high.
- Reset mid-operation: all buffered beats are discarded without handshake. Any beat presented during the reset cycle is not accepted.
- Latency: a beat accepted at edge n is visible on `datak_o`/`valid_o[k]` after edge n (1 cycle). It can be consumed at edge n+1 at the earliest.
- Throughput: 1 beat/cycle per channel when `ready_i[k]` is held high. Aggregate throughput is 1 beat/cycle (single input).
- `ready_o` is combinational from `select_i`, `ready_i` and `full_*`. `valid_o` and `data*_o` are registered only. There is no combinational path from `valid_i` to any output.
- `drop_o` is registered and asserts in the cycle after acceptance.

## Structure
- Shared package holds:
  - Select constants: `SEL_CH0` = 2'b00, `SEL_CH1` = 2'b01, `SEL_CH2` = 2'b10, `SEL_NONE` = 2'b11. The existing 3-to-1 mux uses the same constants.
  - `NUM_CH` = 3.
  - `DROP_CNT_W` = 8.
- Sub-module `demux_slot` (parameter `size`): one-entry buffer with `wr_en`, `wr_data`, `full_o`, `data_o`, `rd_i`, `clk_i`, `rst_i`. It is instantiated three times. The top holds the select decode, `ready_o` logic and drop counter.

## Test plan
- Reset then idle: all outputs 0, `ready_o` 0 during reset and 1 afterwards with `valid_i` = 0.
- Three beats A5A5_0000/sel 00, 1111_1111/sel 01, DEAD_BEEF/sel 10 with `ready_i` = 000:
  - all accepted on consecutive cycles.
  - `valid_o` goes 001, 011, 111, with the matching data on each channel.
  - a 4th beat to sel 00 gets `ready_o` = 0 until `ready_i[0]` = 1, then is accepted in that same cycle.
- Back-pressure isolation: ch1 full with `ready_i[1]` = 0; 10 beats to ch2 with `ready_i[2]` = 1 all pass at 1/cycle; ch1 data is unchanged.
- Drain/refill same cycle: ch0 full with 0x1, `ready_i[0]` = 1, beat 0x2/sel 00 presented. Consumer sees 0x1, next cycle `data0_o` = 0x2 and `valid_o[0]` stays 1.
- Drops: 300 beats with sel 11. `ready_o` = 1 throughout, a `drop_o` pulse follows each, `drop_cnt_o` saturates at 255, no channel changes.
- Mid-operation reset: all channels full, assert `rst_i` for one cycle with `valid_i` = 1. `valid_o` = 000, data = 0, `drop_cnt_o` = 0, and the presented beat is not delivered.

Source files
------------

// File: rtl/demux_1to3_buf_pkg.sv
// Shared definitions for the 1-to-3 demux and its sibling 3-to-1 select mux.
package demux_1to3_buf_pkg;

  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    SEL_CH0  = 2'b00,
    SEL_CH1  = 2'b01,
    SEL_CH2  = 2'b10,
    SEL_NONE = 2'b11
  } sel_e;

  function automatic logic [NUM_CH-1:0] sel_onehot(input sel_e sel);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (sel)
      SEL_CH0: oh = 3'b001;
      SEL_CH1: oh = 3'b010;
      SEL_CH2: oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_1to3_buf_slot.sv
// One-entry channel buffer; a write wins over a same-cycle drain so full stays set.
module demux_slot #(
  parameter int unsigned size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en,
  input  logic [size-1:0] wr_data,
  input  logic            rd_i,
  output logic            full_o,
  output logic [size-1:0] data_o
);

  logic            full_q;
  logic [size-1:0] buf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else if (wr_en) begin
      full_q <= 1'b1;
      buf_q  <= wr_data;
    end else if (rd_i) begin
      // buf_q holds its last value after a drain
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = buf_q;

endmodule

// File: rtl/demux_1to3_buf.sv
// Registered 1-to-3 demux: select decode, input handshake and drop counter
// around three independent one-entry channel buffers.
module demux_1to3_buf
  import demux_1to3_buf_pkg::*;
#(
  parameter int unsigned size = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [size-1:0]       data_i,
  input  logic [1:0]            select_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [size-1:0]       data0_o,
  output logic [size-1:0]       data1_o,
  output logic [size-1:0]       data2_o,
  output logic [NUM_CH-1:0]     valid_o,
  input  logic [NUM_CH-1:0]     ready_i,
  output logic                  drop_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  sel_e              sel;
  logic [NUM_CH-1:0] target;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] wr_en;
  logic              accept;
  logic              drop_hit;
  logic [size-1:0]   slot_data [NUM_CH];

  logic                  drop_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  assign sel    = sel_e'(select_i);
  assign target = sel_onehot(sel);

  // Addressed channel may accept when empty or when it drains this same cycle.
  always_comb begin
    ready_o = 1'b0;
    if (!rst_i) begin
      if (sel == SEL_NONE) ready_o = 1'b1;
      else                 ready_o = |(target & (~full | ready_i));
    end
  end

  always_comb begin
    accept   = valid_i && ready_o;
    wr_en    = {NUM_CH{accept}} & target;
    drop_hit = accept && (sel == SEL_NONE);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.size(size)) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr_en   (wr_en[k]),
      .wr_data (data_i),
      .rd_i    (ready_i[k]),
      .full_o  (full[k]),
      .data_o  (slot_data[k])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q <= drop_hit;
      if (drop_hit && (drop_cnt_q != '1))
        drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign valid_o    = full;
  assign data0_o    = slot_data[0];
  assign data1_o    = slot_data[1];
  assign data2_o    = slot_data[2];
  assign drop_o     = drop_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_demux_1to3_buf.sv
// Directed bench for demux_1to3_buf with hand-computed expected values.
module tb_demux_1to3_buf;

  logic        clk;
  logic        rst_i;
  logic [31:0] data_i;
  logic [1:0]  select_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data0_o, data1_o, data2_o;
  logic [2:0]  valid_o;
  logic [2:0]  ready_i;
  logic        drop_o;
  logic [7:0]  drop_cnt_o;

  int vectors;
  int miscompares;

  demux_1to3_buf #(.size(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .select_i   (select_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data0_o    (data0_o),
    .data1_o    (data1_o),
    .data2_o    (data2_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .drop_o     (drop_o),
    .drop_cnt_o (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 3'b000; select_i = 2'b00; data_i = '0;
    tick();
    tick();
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b exp=0", ready_o); end
    vectors++; if (valid_o !== 3'b000) begin miscompares++; $display("FAIL rst_valid got=%b exp=000", valid_o); end
    vectors++; if ({data0_o, data1_o, data2_o} !== 96'h0) begin miscompares++; $display("FAIL rst_data got=%h_%h_%h exp=0", data0_o, data1_o, data2_o); end
    vectors++; if (drop_o !== 1'b0) begin miscompares++; $display("FAIL rst_drop got=%b exp=0", drop_o); end
    vectors++; if (drop_cnt_o !== 8'd0) begin miscompares++; $display("FAIL rst_dropcnt got=%0d exp=0", drop_cnt_o); end
    rst_i = 1'b0;
    #1;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL idle_ready got=%b exp=1", ready_o); end
    tick();
    vectors++; if (valid_o !== 3'b000) begin miscompares++; $display("FAIL idle_valid got=%b exp=000", valid_o); end
  endtask

  task automatic test_fill;
    logic [31:0] beats [3];
    logic [2:0]  exp_v [3];
    beats[0] = 32'hA5A5_0000; beats[1] = 32'h1111_1111; beats[2] = 32'hDEAD_BEEF;
    exp_v[0] = 3'b001;        exp_v[1] = 3'b011;        exp_v[2] = 3'b111;
    ready_i = 3'b000;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; data_i = beats[i]; select_i = 2'(i);
      #1;
      vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, ready_o); end
      tick();
      vectors++; if (valid_o !== exp_v[i]) begin miscompares++; $display("FAIL fill_valid[%0d] got=%b exp=%b", i, valid_o, exp_v[i]); end
    end
    vectors++; if (data0_o !== 32'hA5A5_0000) begin miscompares++; $display("FAIL fill_d0 got=%h exp=a5a50000", data0_o); end
    vectors++; if (data1_o !== 32'h1111_1111) begin miscompares++; $display("FAIL fill_d1 got=%h exp=11111111", data1_o); end
    vectors++; if (data2_o !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL fill_d2 got=%h exp=deadbeef", data2_o); end
    // fourth beat to full ch0 stalls until its consumer is ready
    data_i = 32'h1234_5678; select_i = 2'b00;
    #1;
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL stall_ready got=%b exp=0", ready_o); end
    tick();
    vectors++; if (data0_o !== 32'hA5A5_0000) begin miscompares++; $display("FAIL stall_d0 got=%h exp=a5a50000", data0_o); end
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL stall_ready2 got=%b exp=0", ready_o); end
    ready_i = 3'b001;
    #1;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL unstall_ready got=%b exp=1", ready_o); end
    tick();
    vectors++; if (data0_o !== 32'h1234_5678) begin miscompares++; $display("FAIL unstall_d0 got=%h exp=12345678", data0_o); end
    vectors++; if (valid_o !== 3'b111) begin miscompares++; $display("FAIL unstall_valid got=%b exp=111", valid_o); end
    valid_i = 1'b0; ready_i = 3'b000;
  endtask

  task automatic test_back_pressure;
    ready_i = 3'b100;
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1; select_i = 2'b10; data_i = 32'hC000_0000 + 32'(i);
      #1;
      vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_ready[%0d] got=%b exp=1", i, ready_o); end
      tick();
      vectors++; if (data2_o !== 32'hC000_0000 + 32'(i)) begin miscompares++; $display("FAIL bp_d2[%0d] got=%h exp=%h", i, data2_o, 32'hC000_0000 + 32'(i)); end
    end
    valid_i = 1'b0;
    vectors++; if (valid_o !== 3'b111) begin miscompares++; $display("FAIL bp_valid got=%b exp=111", valid_o); end
    vectors++; if (data1_o !== 32'h1111_1111) begin miscompares++; $display("FAIL bp_d1 got=%h exp=11111111", data1_o); end
    tick();
    vectors++; if (valid_o !== 3'b011) begin miscompares++; $display("FAIL bp_drain_valid got=%b exp=011", valid_o); end
    vectors++; if (data2_o !== 32'hC000_0009) begin miscompares++; $display("FAIL bp_hold_d2 got=%h exp=c0000009", data2_o); end
    ready_i = 3'b000;
  endtask

  task automatic test_drain_refill;
    ready_i = 3'b001; valid_i = 1'b0;
    tick();
    vectors++; if (valid_o !== 3'b010) begin miscompares++; $display("FAIL dr_empty_valid got=%b exp=010", valid_o); end
    vectors++; if (data0_o !== 32'h1234_5678) begin miscompares++; $display("FAIL dr_hold_d0 got=%h exp=12345678", data0_o); end
    ready_i = 3'b000; valid_i = 1'b1; select_i = 2'b00; data_i = 32'h1;
    tick();
    vectors++; if (data0_o !== 32'h1) begin miscompares++; $display("FAIL dr_load_d0 got=%h exp=1", data0_o); end
    ready_i = 3'b001; data_i = 32'h2;
    #1;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL dr_ready got=%b exp=1", ready_o); end
    vectors++; if (data0_o !== 32'h1) begin miscompares++; $display("FAIL dr_consumer_d0 got=%h exp=1", data0_o); end
    tick();
    vectors++; if (data0_o !== 32'h2) begin miscompares++; $display("FAIL dr_refill_d0 got=%h exp=2", data0_o); end
    vectors++; if (valid_o !== 3'b011) begin miscompares++; $display("FAIL dr_refill_valid got=%b exp=011", valid_o); end
    valid_i = 1'b0; ready_i = 3'b000;
  endtask

  task automatic test_drops;
    int exp_cnt;
    ready_i = 3'b000;
    for (int i = 0; i < 300; i++) begin
      valid_i = 1'b1; select_i = 2'b11; data_i = $urandom;
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      #1;
      vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL drop_ready[%0d] got=%b exp=1", i, ready_o); end
      tick();
      vectors++; if (drop_o !== 1'b1) begin miscompares++; $display("FAIL drop_pulse[%0d] got=%b exp=1", i, drop_o); end
      vectors++; if (drop_cnt_o !== 8'(exp_cnt)) begin miscompares++; $display("FAIL drop_cnt[%0d] got=%0d exp=%0d", i, drop_cnt_o, exp_cnt); end
    end
    valid_i = 1'b0;
    tick();
    vectors++; if (drop_o !== 1'b0) begin miscompares++; $display("FAIL drop_end got=%b exp=0", drop_o); end
    vectors++; if (drop_cnt_o !== 8'd255) begin miscompares++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt_o); end
    vectors++; if (valid_o !== 3'b011) begin miscompares++; $display("FAIL drop_valid got=%b exp=011", valid_o); end
    vectors++; if ({data0_o, data1_o, data2_o} !== {32'h2, 32'h1111_1111, 32'hC000_0009}) begin
      miscompares++; $display("FAIL drop_data got=%h_%h_%h exp=00000002_11111111_c0000009", data0_o, data1_o, data2_o);
    end
  endtask

  task automatic test_mid_reset;
    valid_i = 1'b1; select_i = 2'b10; data_i = 32'hBBBB_BBBB; ready_i = 3'b000;
    tick();
    vectors++; if (valid_o !== 3'b111) begin miscompares++; $display("FAIL mr_full got=%b exp=111", valid_o); end
    rst_i = 1'b1; select_i = 2'b00; data_i = 32'h7777_7777; ready_i = 3'b001;
    #1;
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL mr_ready got=%b exp=0", ready_o); end
    tick();
    vectors++; if (valid_o !== 3'b000) begin miscompares++; $display("FAIL mr_valid got=%b exp=000", valid_o); end
    vectors++; if ({data0_o, data1_o, data2_o} !== 96'h0) begin miscompares++; $display("FAIL mr_data got=%h_%h_%h exp=0", data0_o, data1_o, data2_o); end
    vectors++; if (drop_cnt_o !== 8'd0) begin miscompares++; $display("FAIL mr_dropcnt got=%0d exp=0", drop_cnt_o); end
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 3'b000;
    tick();
    vectors++; if (valid_o !== 3'b000) begin miscompares++; $display("FAIL mr_nodeliver got=%b exp=000", valid_o); end
    vectors++; if (data0_o !== 32'h0) begin miscompares++; $display("FAIL mr_d0 got=%h exp=0", data0_o); end
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL mr_ready_after got=%b exp=1", ready_o); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fill();
    test_back_pressure();
    test_drain_refill();
    test_drops();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
